// File: rtl/cga_intr_pidpie.sv
// CGA interrupt request register stage: PID/PIE registers, external edge detect, masked request vector.
// Optional INTR_SYNC2_EN adds a second synchronizer flop ahead of the edge detector.
module cga_intr_pidpie #(
    parameter int EXT_LO = 10
) (
    input  logic        sysclk,
    input  logic        sys_rst,
    input  logic [3:0]  IRQ_EXT_3_0,
    input  logic        WR_PID,
    input  logic        WR_PIE,
    input  logic [15:0] WDATA_15_0,
    input  logic        ACK,
    input  logic [3:0]  ACK_LVL_3_0,
    input  logic        INTON,
    output logic [15:0] MIREQ_15_0_N,
    output logic [15:0] PID_15_0,
    output logic [15:0] PIE_15_0,
    output logic        IRQ_PEND,
    output logic [3:0]  OVF_3_0
);

    logic [15:0] pid_q, pid_d;
    logic [15:0] pie_q, pie_d;
    logic [3:0]  ovf_q, ovf_d;
    logic [3:0]  s1_q, s1_d;
    logic [3:0]  sdly_q, sdly_d;
    logic [3:0]  edge_det;
    logic [3:0]  ovf_set;
    logic [15:0] base, clr_vec, set_vec;
`ifdef INTR_SYNC2_EN
    logic [3:0]  s0_q, s0_d;
`endif

    always_comb begin
`ifdef INTR_SYNC2_EN
        s0_d = IRQ_EXT_3_0;
        s1_d = s0_q;
`else
        s1_d = IRQ_EXT_3_0;
`endif
        sdly_d   = s1_q;
        edge_det = s1_q & ~sdly_q;
        set_vec  = 16'(edge_det) << EXT_LO;
        clr_vec  = ACK ? (16'd1 << ACK_LVL_3_0) : 16'd0;
        base     = WR_PID ? WDATA_15_0 : pid_q;
        // Set is OR'd last so a new edge beats a same-cycle ACK or write.
        pid_d    = (base & ~clr_vec) | set_vec;
        pie_d    = WR_PIE ? WDATA_15_0 : pie_q;
        // Overrun judged on the registered PID bit, regardless of any clear this cycle.
        ovf_set  = edge_det & pid_q[EXT_LO +: 4];
        ovf_d    = (WR_PID ? 4'd0 : ovf_q) | ovf_set;
    end

    always_ff @(posedge sysclk) begin
        if (sys_rst) begin
            pid_q  <= '0;
            pie_q  <= '0;
            ovf_q  <= '0;
            s1_q   <= '0;
            sdly_q <= '0;
`ifdef INTR_SYNC2_EN
            s0_q   <= '0;
`endif
        end else begin
            pid_q  <= pid_d;
            pie_q  <= pie_d;
            ovf_q  <= ovf_d;
            s1_q   <= s1_d;
            sdly_q <= sdly_d;
`ifdef INTR_SYNC2_EN
            s0_q   <= s0_d;
`endif
        end
    end

    assign MIREQ_15_0_N = ~(pid_q & pie_q & {16{INTON}});
    assign IRQ_PEND     = ~(&MIREQ_15_0_N);
    assign PID_15_0     = pid_q;
    assign PIE_15_0     = pie_q;
    assign OVF_3_0      = ovf_q;

endmodule

// File: tb/tb_cga_intr_pidpie.sv
// Bench for cga_intr_pidpie: directed test-plan steps followed by randomized cycles,
// all checked against a cycle-level behavioural model of the PID/PIE/overrun rules.
module tb_cga_intr_pidpie;

`ifdef INTR_SYNC2_EN
    localparam int NS = 2;
`else
    localparam int NS = 1;
`endif
    localparam int EXT_LO = 10;

    logic        clk = 1'b0;
    logic        sys_rst;
    logic [3:0]  irq;
    logic        wr_pid, wr_pie, ack, inton;
    logic [15:0] wdata;
    logic [3:0]  ack_lvl;
    logic [15:0] mireq_n, pid, pie;
    logic        irq_pend;
    logic [3:0]  ovf;

    logic [15:0] m_pid, m_pie;
    logic [3:0]  m_ovf;
    logic [3:0]  hist [0:2];
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    cga_intr_pidpie #(.EXT_LO(EXT_LO)) dut (
        .sysclk      (clk),
        .sys_rst     (sys_rst),
        .IRQ_EXT_3_0 (irq),
        .WR_PID      (wr_pid),
        .WR_PIE      (wr_pie),
        .WDATA_15_0  (wdata),
        .ACK         (ack),
        .ACK_LVL_3_0 (ack_lvl),
        .INTON       (inton),
        .MIREQ_15_0_N(mireq_n),
        .PID_15_0    (pid),
        .PIE_15_0    (pie),
        .IRQ_PEND    (irq_pend),
        .OVF_3_0     (ovf)
    );

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_model();
        logic [15:0] act;
        act = m_pid & m_pie & {16{inton}};
        chk("pid", pid, m_pid);
        chk("pie", pie, m_pie);
        chk("ovf", {12'd0, ovf}, {12'd0, m_ovf});
        chk("mireq_n", mireq_n, ~act);
        chk("irq_pend", {15'd0, irq_pend}, {15'd0, (act != 16'd0)});
    endtask

    // One clock: drive controls, advance the model, then compare after the edge.
    task automatic step(input logic wp, input logic we, input logic [15:0] wd,
                        input logic ak, input logic [3:0] al);
        logic [15:0] nxt;
        logic [3:0]  e, oset;
        wr_pid = wp; wr_pie = we; wdata = wd; ack = ak; ack_lvl = al;
        if (sys_rst) begin
            m_pid = '0; m_pie = '0; m_ovf = '0;
            for (int i = 0; i < 3; i++) hist[i] = '0;
        end else begin
            e    = hist[NS-1] & ~hist[NS];
            oset = '0;
            nxt  = wp ? wd : m_pid;
            if (ak) nxt[al] = 1'b0;
            for (int i = 0; i < 4; i++) begin
                if (e[i]) begin
                    if (m_pid[EXT_LO+i]) oset[i] = 1'b1;
                    nxt[EXT_LO+i] = 1'b1;
                end
            end
            m_ovf = (wp ? 4'd0 : m_ovf) | oset;
            m_pid = nxt;
            if (we) m_pie = wd;
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = irq;
        end
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 16'h0000, 1'b0, 4'd0);
    endtask

    initial begin
        sys_rst = 1'b1; irq = 4'hF; inton = 1'b1;
        wr_pid = 1'b0; wr_pie = 1'b0; wdata = '0; ack = 1'b0; ack_lvl = '0;
        m_pid = '0; m_pie = '0; m_ovf = '0;
        for (int i = 0; i < 3; i++) hist[i] = '0;

        // Reset wins over WR_PIE and active external lines
        step(1'b0, 1'b1, 16'hFFFF, 1'b0, 4'd0);
        chk("rst_pid", pid, 16'h0000);
        chk("rst_pie", pie, 16'h0000);
        chk("rst_mireq", mireq_n, 16'hFFFF);
        chk("rst_ovf", {12'd0, ovf}, 16'h0000);
        irq = 4'h0;
        step(1'b0, 1'b1, 16'hFFFF, 1'b0, 4'd0);
        sys_rst = 1'b0;
        repeat (3) idle();

        // Write and mask
        step(1'b0, 1'b1, 16'h2400, 1'b0, 4'd0);
        step(1'b1, 1'b0, 16'h2C00, 1'b0, 4'd0);
        chk("mask_mireq", mireq_n, 16'hDBFF);
        chk("mask_pend", {15'd0, irq_pend}, 16'd1);
        inton = 1'b0;
        idle();
        chk("inton0_mireq", mireq_n, 16'hFFFF);
        chk("inton0_pend", {15'd0, irq_pend}, 16'd0);
        inton = 1'b1;

        // External edge latency on level 13
        step(1'b1, 1'b0, 16'h0000, 1'b0, 4'd0);
        step(1'b0, 1'b1, 16'h3C00, 1'b0, 4'd0);
        irq[3] = 1'b1;
        repeat (NS) idle();
        chk("ext_early_pid13", {15'd0, pid[13]}, 16'd0);
        idle();
        chk("ext_pid13", {15'd0, pid[13]}, 16'd1);
        chk("ext_mireq", mireq_n, 16'hDFFF);

        // ACK vs edge collision on level 11
        step(1'b1, 1'b0, 16'h0800, 1'b0, 4'd0);
        irq[1] = 1'b1;
        idle();
        repeat (NS-1) idle();
        step(1'b0, 1'b0, 16'h0000, 1'b1, 4'd11);
        chk("coll_pid11", {15'd0, pid[11]}, 16'd1);
        chk("coll_ovf", {12'd0, ovf}, 16'h0002);
        step(1'b0, 1'b0, 16'h0000, 1'b1, 4'd11);
        chk("ack_pid11", {15'd0, pid[11]}, 16'd0);

        // Overrun clear by WR_PID
        step(1'b1, 1'b0, 16'h0000, 1'b0, 4'd0);
        chk("ovfclr_ovf", {12'd0, ovf}, 16'h0000);
        chk("ovfclr_pid", pid, 16'h0000);

        // Overrun clear overridden by a simultaneous new overrun
        step(1'b1, 1'b0, 16'h0800, 1'b0, 4'd0);
        irq[1] = 1'b0;
        repeat (NS+1) idle();
        irq[1] = 1'b1;
        idle();
        repeat (NS-1) idle();
        idle();
        chk("ovr_first", {12'd0, ovf}, 16'h0002);
        irq[1] = 1'b0;
        repeat (NS+1) idle();
        irq[1] = 1'b1;
        idle();
        repeat (NS-1) idle();
        step(1'b1, 1'b0, 16'h0000, 1'b0, 4'd0);
        chk("ovr_keep_ovf", {12'd0, ovf}, 16'h0002);
        chk("ovr_keep_pid", pid, 16'h0800);

        // Reset mid-operation with lines held high
        step(1'b1, 1'b1, 16'hFFFF, 1'b0, 4'd0);
        irq = 4'hF;
        repeat (NS+2) idle();
        sys_rst = 1'b1;
        idle();
        chk("mid_rst_pid", pid, 16'h0000);
        chk("mid_rst_pie", pie, 16'h0000);
        chk("mid_rst_mireq", mireq_n, 16'hFFFF);
        sys_rst = 1'b0;
        step(1'b0, 1'b1, 16'hFFFF, 1'b0, 4'd0);
        repeat (NS-1) idle();
        chk("mid_rel_early", pid, 16'h0000);
        idle();
        chk("mid_rel_pid", pid, 16'h3C00);
        chk("mid_rel_ovf", {12'd0, ovf}, 16'h0000);
        idle();
        chk("mid_rel_once", {12'd0, ovf}, 16'h0000);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            sys_rst = ($urandom_range(0, 49) == 0);
            irq     = 4'($urandom);
            inton   = ($urandom_range(0, 7) != 0);
            step(($urandom_range(0, 9) == 0), ($urandom_range(0, 7) == 0),
                 16'($urandom), ($urandom_range(0, 2) == 0), 4'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
